fp_rnd_pipe: RTL and testbench

Two-stage pipelined rounding and packing unit that consumes the `fp_rnd` record emitted by the FMA, divide/sqrt and conversion datapaths. It produces the final IEEE-754 result and the RISC-V `fflags` value. It applies the rounding mode, renormalises after mantissa carry, detects overflow and underflow, substitutes special values, and NaN-boxes single-precision results. It sits between the arithmetic pipelines and the FPU writeback mux.

---
 rtl/fp_rnd_pipe_if.sv | 34 +++
 rtl/fp_rnd_pipe.sv | 169 ++++++++++++++++
 tb/tb_fp_rnd_pipe.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_rnd_pipe_if.sv
// Record and result bundle between the arithmetic datapaths, the rounding
// unit and the writeback mux.
interface fp_rnd_pipe_if;
    logic        valid_i;
    logic        sig_i;
    logic [13:0] expo_i;
    logic [53:0] mant_i;
    logic [1:0]  rema_i;
    logic [1:0]  fmt_i;
    logic [2:0]  rm_i;
    logic [2:0]  grs_i;
    logic        snan_i;
    logic        qnan_i;
    logic        dbz_i;
    logic        inf_i;
    logic        zero_i;
    logic [63:0] result_o;
    logic [4:0]  flags_o;
    logic        valid_o;

    // Producer side: drives the record, observes the packed result.
    modport master (
        output valid_i, sig_i, expo_i, mant_i, rema_i, fmt_i, rm_i, grs_i,
        output snan_i, qnan_i, dbz_i, inf_i, zero_i,
        input  result_o, flags_o, valid_o
    );

    // Rounding unit side.
    modport slave (
        input  valid_i, sig_i, expo_i, mant_i, rema_i, fmt_i, rm_i, grs_i,
        input  snan_i, qnan_i, dbz_i, inf_i, zero_i,
        output result_o, flags_o, valid_o
    );
endinterface

// File: rtl/fp_rnd_pipe.sv
// Two-stage rounding/packing unit: stage 1 applies the rounding increment,
// stage 2 renormalises, detects overflow/underflow, substitutes specials and
// NaN-boxes single-precision results.
module fp_rnd_pipe (
    input  logic         clock,
    input  logic         reset,
    fp_rnd_pipe_if.slave bus
);

    localparam logic [2:0] RmRne = 3'd0;
    localparam logic [2:0] RmRtz = 3'd1;
    localparam logic [2:0] RmRdn = 3'd2;
    localparam logic [2:0] RmRup = 3'd3;
    localparam logic [2:0] RmRmm = 3'd4;

    // Stage 1 combinational
    logic        inexact;
    logic        rnd_up;
    logic [54:0] mant_sum;

    // Stage 1 registers
    logic        s1_valid;
    logic        s1_sig;
    logic [13:0] s1_expo;
    logic [54:0] s1_mant;
    logic        s1_dbl;
    logic [2:0]  s1_rm;
    logic        s1_inexact;
    logic        s1_tiny;
    logic        s1_snan;
    logic        s1_qnan;
    logic        s1_dbz;
    logic        s1_inf;
    logic        s1_zero;

    // Stage 2 combinational
    logic        carry;
    logic [53:0] mant_n;
    logic [14:0] expo_n;
    logic        hidden;
    logic        ovf;
    logic        to_max;
    logic [31:0] r32;
    logic [63:0] r64;
    logic [63:0] res_next;
    logic [4:0]  flags_next;

    // Output registers
    logic        out_valid;
    logic [63:0] out_result;
    logic [4:0]  out_flags;

    logic unused_bits;
    assign unused_bits = ^{bus.fmt_i[1], mant_n[53]};

    // Round-up decision and rounding increment; modes 5-7 fall back to RNE.
    always_comb begin
        inexact = |{bus.grs_i, bus.rema_i};
        rnd_up  = 1'b0;
        case (bus.rm_i)
            RmRtz:   rnd_up = 1'b0;
            RmRdn:   rnd_up = bus.sig_i & inexact;
            RmRup:   rnd_up = ~bus.sig_i & inexact;
            RmRmm:   rnd_up = bus.grs_i[2];
            default: rnd_up = bus.grs_i[2] &
                              (bus.grs_i[1] | bus.grs_i[0] | (|bus.rema_i) | bus.mant_i[0]);
        endcase
        mant_sum = {1'b0, bus.mant_i} + 55'(rnd_up);
    end

    // Stage 1 register; loads every cycle, qualified downstream by s1_valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_sig     <= 1'b0;
            s1_expo    <= '0;
            s1_mant    <= '0;
            s1_dbl     <= 1'b0;
            s1_rm      <= '0;
            s1_inexact <= 1'b0;
            s1_tiny    <= 1'b0;
            s1_snan    <= 1'b0;
            s1_qnan    <= 1'b0;
            s1_dbz     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
        end else begin
            s1_valid   <= bus.valid_i;
            s1_sig     <= bus.sig_i;
            s1_expo    <= bus.expo_i;
            s1_mant    <= mant_sum;
            s1_dbl     <= bus.fmt_i[0];
            s1_rm      <= bus.rm_i;
            s1_inexact <= inexact;
            s1_tiny    <= (bus.expo_i == 14'd0);
            s1_snan    <= bus.snan_i;
            s1_qnan    <= bus.qnan_i;
            s1_dbz     <= bus.dbz_i;
            s1_inf     <= bus.inf_i;
            s1_zero    <= bus.zero_i;
        end
    end

    // Renormalise, detect overflow, pack and apply special-value overrides.
    always_comb begin
        carry  = s1_dbl ? s1_mant[53] : s1_mant[24];
        mant_n = carry ? s1_mant[54:1] : s1_mant[53:0];
        expo_n = {1'b0, s1_expo} + 15'(carry);
        hidden = s1_dbl ? mant_n[52] : mant_n[23];
        // A subnormal that rounded up into the hidden bit becomes the smallest normal.
        if (expo_n == 15'd0 && hidden) begin
            expo_n = 15'd1;
        end
        ovf    = s1_dbl ? (expo_n >= 15'd2047) : (expo_n >= 15'd255);
        to_max = (s1_rm == RmRtz) || (s1_rm == RmRdn && !s1_sig) ||
                 (s1_rm == RmRup && s1_sig);

        r32        = {s1_sig, expo_n[7:0], mant_n[22:0]};
        r64        = {s1_sig, expo_n[10:0], mant_n[51:0]};
        flags_next = {3'b000, s1_tiny & s1_inexact, s1_inexact};

        if (ovf) begin
            flags_next = 5'b00101;
            if (to_max) begin
                r32 = {s1_sig, 31'h7F7F_FFFF};
                r64 = {s1_sig, 63'h7FEF_FFFF_FFFF_FFFF};
            end else begin
                r32 = {s1_sig, 31'h7F80_0000};
                r64 = {s1_sig, 63'h7FF0_0000_0000_0000};
            end
        end

        if (s1_snan || s1_qnan) begin
            r32        = 32'h7FC0_0000;
            r64        = 64'h7FF8_0000_0000_0000;
            flags_next = s1_snan ? 5'b10000 : 5'b00000;
        end else if (s1_dbz || s1_inf) begin
            r32        = {s1_sig, 31'h7F80_0000};
            r64        = {s1_sig, 63'h7FF0_0000_0000_0000};
            flags_next = s1_dbz ? 5'b01000 : 5'b00000;
        end else if (s1_zero) begin
            r32        = {s1_sig, 31'h0};
            r64        = {s1_sig, 63'h0};
            flags_next = 5'b00000;
        end

        res_next = s1_dbl ? r64 : {32'hFFFF_FFFF, r32};
    end

    // Output register; result and flags hold while no valid record arrives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_next;
                out_flags  <= flags_next;
            end
        end
    end

    assign bus.valid_o  = out_valid;
    assign bus.result_o = out_result;
    assign bus.flags_o  = out_flags;

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Self-checking bench for fp_rnd_pipe: vector table streamed through a
// scoreboard, plus throughput, output-hold and mid-flight reset sequences.
module tb_fp_rnd_pipe;

    typedef struct {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic [1:0]  rema;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  grs;
        logic [4:0]  spec;   // {snan, qnan, dbz, inf, zero}
        logic [63:0] res;
        logic [4:0]  flg;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flg;
        int          due;
        int          idx;
    } sb_t;

    localparam int NumVec = 22;

    logic clock;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    vec_t vecs [NumVec];
    sb_t  sb [$];

    fp_rnd_pipe_if bus ();

    fp_rnd_pipe dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s", name);
    endtask

    task automatic idle();
        bus.valid_i = 1'b0;
        bus.sig_i   = 1'b0;
        bus.expo_i  = '0;
        bus.mant_i  = '0;
        bus.rema_i  = '0;
        bus.fmt_i   = '0;
        bus.rm_i    = '0;
        bus.grs_i   = '0;
        {bus.snan_i, bus.qnan_i, bus.dbz_i, bus.inf_i, bus.zero_i} = 5'b0;
    endtask

    task automatic drive(input int i);
        sb_t e;
        bus.valid_i = 1'b1;
        bus.sig_i   = vecs[i].sig;
        bus.expo_i  = vecs[i].expo;
        bus.mant_i  = vecs[i].mant;
        bus.rema_i  = vecs[i].rema;
        bus.fmt_i   = vecs[i].fmt;
        bus.rm_i    = vecs[i].rm;
        bus.grs_i   = vecs[i].grs;
        {bus.snan_i, bus.qnan_i, bus.dbz_i, bus.inf_i, bus.zero_i} = vecs[i].spec;
        e.res = vecs[i].res;
        e.flg = vecs[i].flg;
        e.due = cyc + 2;
        e.idx = i;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: pops one expectation per valid_o cycle.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.valid_o) begin
                if (sb.size() == 0) begin
                    fail("unexpected valid_o");
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check($sformatf("latency v%0d", e.idx), 64'(cyc), 64'(e.due));
                    check($sformatf("result v%0d", e.idx), bus.result_o, e.res);
                    check($sformatf("flags v%0d", e.idx), 64'(bus.flags_o), 64'(e.flg));
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                fail($sformatf("missing output v%0d", sb[0].idx));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int cnt;
        total = 0;
        bad   = 0;
        cyc   = 0;

        vecs[0]  = '{1'b0, 14'd127,  54'h800000,         2'd0, 2'd0, 3'd0, 3'b000, 5'b00000,
                     64'hFFFFFFFF3F800000, 5'h00};
        vecs[1]  = '{1'b0, 14'd1023, 54'h1FFFFFFFFFFFFF, 2'd0, 2'd1, 3'd0, 3'b100, 5'b00000,
                     64'h4000000000000000, 5'h01};
        vecs[2]  = '{1'b0, 14'd254,  54'hFFFFFF,         2'd0, 2'd0, 3'd0, 3'b110, 5'b00000,
                     64'hFFFFFFFF7F800000, 5'h05};
        vecs[3]  = '{1'b0, 14'd300,  54'h800000,         2'd0, 2'd0, 3'd1, 3'b000, 5'b00000,
                     64'hFFFFFFFF7F7FFFFF, 5'h05};
        vecs[4]  = '{1'b0, 14'd0,    54'h000001,         2'd0, 2'd0, 3'd3, 3'b010, 5'b00000,
                     64'hFFFFFFFF00000002, 5'h03};
        vecs[5]  = '{1'b0, 14'd0,    54'h0,              2'd0, 2'd1, 3'd0, 3'b000, 5'b10010,
                     64'h7FF8000000000000, 5'h10};
        vecs[6]  = '{1'b1, 14'd0,    54'h0,              2'd0, 2'd0, 3'd0, 3'b000, 5'b00100,
                     64'hFFFFFFFFFF800000, 5'h08};
        vecs[7]  = '{1'b1, 14'd0,    54'h0,              2'd0, 2'd1, 3'd0, 3'b000, 5'b00001,
                     64'h8000000000000000, 5'h00};
        vecs[8]  = '{1'b0, 14'd127,  54'h800000,         2'd0, 2'd0, 3'd0, 3'b100, 5'b00000,
                     64'hFFFFFFFF3F800000, 5'h01};
        vecs[9]  = '{1'b0, 14'd127,  54'h800001,         2'd0, 2'd0, 3'd0, 3'b100, 5'b00000,
                     64'hFFFFFFFF3F800002, 5'h01};
        vecs[10] = '{1'b1, 14'd127,  54'h800000,         2'd0, 2'd0, 3'd2, 3'b001, 5'b00000,
                     64'hFFFFFFFFBF800001, 5'h01};
        vecs[11] = '{1'b1, 14'd127,  54'h800000,         2'd0, 2'd0, 3'd3, 3'b001, 5'b00000,
                     64'hFFFFFFFFBF800000, 5'h01};
        vecs[12] = '{1'b0, 14'd127,  54'h800000,         2'd0, 2'd0, 3'd4, 3'b100, 5'b00000,
                     64'hFFFFFFFF3F800001, 5'h01};
        vecs[13] = '{1'b0, 14'd127,  54'h800000,         2'd1, 2'd0, 3'd0, 3'b000, 5'b00000,
                     64'hFFFFFFFF3F800000, 5'h01};
        vecs[14] = '{1'b0, 14'd127,  54'h800001,         2'd0, 2'd0, 3'd7, 3'b100, 5'b00000,
                     64'hFFFFFFFF3F800002, 5'h01};
        vecs[15] = '{1'b0, 14'd0,    54'h7FFFFF,         2'd0, 2'd0, 3'd0, 3'b100, 5'b00000,
                     64'hFFFFFFFF00800000, 5'h03};
        vecs[16] = '{1'b0, 14'd0,    54'h0,              2'd0, 2'd0, 3'd0, 3'b000, 5'b01100,
                     64'hFFFFFFFF7FC00000, 5'h00};
        vecs[17] = '{1'b1, 14'd2047, 54'h10000000000000, 2'd0, 2'd1, 3'd2, 3'b000, 5'b00000,
                     64'hFFF0000000000000, 5'h05};
        vecs[18] = '{1'b1, 14'd2047, 54'h10000000000000, 2'd0, 2'd1, 3'd3, 3'b000, 5'b00000,
                     64'hFFEFFFFFFFFFFFFF, 5'h05};
        vecs[19] = '{1'b0, 14'd0,    54'h0,              2'd0, 2'd0, 3'd0, 3'b000, 5'b00010,
                     64'hFFFFFFFF7F800000, 5'h00};
        vecs[20] = '{1'b0, 14'd1023, 54'h18000000000000, 2'd0, 2'd1, 3'd0, 3'b000, 5'b00000,
                     64'h3FF8000000000000, 5'h00};
        vecs[21] = '{1'b0, 14'd255,  54'h800000,         2'd0, 2'd0, 3'd2, 3'b000, 5'b00000,
                     64'hFFFFFFFF7F7FFFFF, 5'h05};

        reset = 1'b0;
        idle();
        #1;
        check("reset result_o", bus.result_o, 64'h0);
        check("reset flags_o", 64'(bus.flags_o), 64'h0);
        check("reset valid_o", 64'(bus.valid_o), 64'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Stream the whole table back to back.
        for (int i = 0; i < NumVec; i++) begin
            @(negedge clock);
            drive(i);
        end
        @(negedge clock);
        idle();
        repeat (4) @(negedge clock);

        // Three consecutive records leave on three consecutive cycles.
        @(negedge clock);
        drive(0);
        @(negedge clock);
        drive(9);
        @(negedge clock);
        drive(20);
        check("b2b valid_o 1st", 64'(bus.valid_o), 64'h1);
        @(negedge clock);
        idle();
        check("b2b valid_o 2nd", 64'(bus.valid_o), 64'h1);
        @(negedge clock);
        check("b2b valid_o 3rd", 64'(bus.valid_o), 64'h1);
        @(negedge clock);
        check("b2b valid_o after", 64'(bus.valid_o), 64'h0);
        check("hold result_o", bus.result_o, vecs[20].res);
        check("hold flags_o", 64'(bus.flags_o), 64'(vecs[20].flg));

        // Reset with two records in flight.
        @(negedge clock);
        drive(2);
        @(negedge clock);
        drive(5);
        @(posedge clock);
        #1;
        check("inflight valid_o", 64'(bus.valid_o), 64'h1);
        reset = 1'b0;
        sb.delete();
        #1;
        check("mid-reset valid_o", 64'(bus.valid_o), 64'h0);
        check("mid-reset result_o", bus.result_o, 64'h0);
        check("mid-reset flags_o", 64'(bus.flags_o), 64'h0);
        @(negedge clock);
        idle();
        @(negedge clock);
        reset = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.valid_o) cnt++;
        end
        check("post-reset quiet", 64'(cnt), 64'h0);
        drive(4);
        @(negedge clock);
        idle();

        // Drain with a bounded wait.
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clock);
        while (sb.size() != 0) begin
            fail($sformatf("drain timeout v%0d", sb[0].idx));
            void'(sb.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
